// File: rtl/vram_dbuf_if.sv
// rtl/vram_dbuf_if.sv - CPU data bus bundle for the double-buffered video RAM
interface vram_dbuf_if #(
  parameter int N = 32
);
  logic             write_enable;
  logic             read_enable;
  logic [N-1:0]     address;
  logic [N-1:0]     data_input;
  logic [N/8-1:0]   byte_enable;
  logic [N-1:0]     data_output;
  logic             read_valid;

  modport master (
    output write_enable, read_enable, address, data_input, byte_enable,
    input  data_output, read_valid
  );

  modport slave (
    input  write_enable, read_enable, address, data_input, byte_enable,
    output data_output, read_valid
  );
endinterface

// File: rtl/vram_dbuf.sv
// rtl/vram_dbuf.sv - double-buffered video RAM, swap committed on vsync rise; optional copy-back under VRAM_SWAP_COPY_EN
module vram_dbuf #(
  parameter int N         = 32,
  parameter int DEPTH     = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  vram_dbuf_if.slave              bus,
  input  logic                    swap_req,
  input  logic                    vsync,
  output logic                    swap_pending,
  output logic                    front_sel,
  output logic                    busy,
  output logic [DEPTH-1:0][N-1:0] parallel_output
);

  localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          NB    = N / 8;
  localparam logic [N:0]  LO    = (N+1)'(BASE_ADDR);
  localparam logic [N:0]  HI    = (N+1)'(BASE_ADDR + DEPTH);

`ifdef VRAM_SWAP_COPY_EN
  typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;
`else
  typedef enum logic [1:0] {IDLE, PENDING} state_t;
`endif

  state_t                   state, state_d;
  logic                     commit;
  logic                     vsync_q;
  logic                     vsync_rise;
  logic [DEPTH-1:0][N-1:0]  bank_a, bank_b;
  logic [DEPTH-1:0][N-1:0]  front_bank, back_bank;
  logic                     hit;
  logic [IDX_W-1:0]         idx;
  logic                     wr_go, rd_go;

`ifdef VRAM_SWAP_COPY_EN
  logic [IDX_W-1:0]         copy_cnt;
  logic                     swap_latched;
`endif

  // bank A is front when front_sel is 0; the CPU always sees the other bank
  assign front_bank      = front_sel ? bank_b : bank_a;
  assign back_bank       = front_sel ? bank_a : bank_b;
  assign parallel_output = front_bank;

  assign hit   = ({1'b0, bus.address} >= LO) && ({1'b0, bus.address} < HI);
  assign idx   = IDX_W'(bus.address - N'(BASE_ADDR));
  assign wr_go = bus.write_enable && hit && !busy;
  assign rd_go = bus.read_enable && !bus.write_enable && hit && !busy;

  assign vsync_rise   = vsync && !vsync_q;
  assign swap_pending = (state == PENDING);

`ifdef VRAM_SWAP_COPY_EN
  assign busy = (state == COPY);
`else
  assign busy = 1'b0;
`endif

  // next-state logic: a swap commits only on a vsync rising edge
  always_comb begin
    state_d = state;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (swap_req) begin
          if (vsync_rise) commit  = 1'b1;
          else            state_d = PENDING;
        end
      end
      PENDING: begin
        if (vsync_rise) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef VRAM_SWAP_COPY_EN
      COPY: begin
        if (copy_cnt == IDX_W'(DEPTH - 1))
          state_d = (swap_latched || swap_req) ? PENDING : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef VRAM_SWAP_COPY_EN
    if (commit) state_d = COPY;
`endif
  end

  // state register, vsync edge history and front bank selector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vsync_q   <= 1'b0;
      front_sel <= 1'b0;
    end else begin
      state   <= state_d;
      vsync_q <= vsync;
      if (commit) front_sel <= ~front_sel;
    end
  end

`ifdef VRAM_SWAP_COPY_EN
  // copy word counter; a swap request arriving mid-copy is remembered until the copy ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      copy_cnt     <= '0;
      swap_latched <= 1'b0;
    end else if (commit) begin
      copy_cnt     <= '0;
      swap_latched <= 1'b0;
    end else if (state == COPY) begin
      if (copy_cnt == IDX_W'(DEPTH - 1)) begin
        copy_cnt     <= '0;
        swap_latched <= 1'b0;
      end else begin
        copy_cnt <= copy_cnt + 1'b1;
        if (swap_req) swap_latched <= 1'b1;
      end
    end
  end
`endif

  // bank storage: byte-masked CPU writes into the back bank, plus front-to-back copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_a <= '0;
      bank_b <= '0;
    end else begin
      if (wr_go) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.byte_enable[b]) begin
            if (front_sel) bank_a[idx][8*b +: 8] <= bus.data_input[8*b +: 8];
            else           bank_b[idx][8*b +: 8] <= bus.data_input[8*b +: 8];
          end
        end
      end
`ifdef VRAM_SWAP_COPY_EN
      if (state == COPY) begin
        if (front_sel) bank_a[copy_cnt] <= bank_b[copy_cnt];
        else           bank_b[copy_cnt] <= bank_a[copy_cnt];
      end
`endif
    end
  end

  // registered CPU read of the back bank, zero whenever no read was issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data_output <= '0;
      bus.read_valid  <= 1'b0;
    end else begin
      bus.read_valid  <= rd_go;
      bus.data_output <= rd_go ? back_bank[idx] : '0;
    end
  end

endmodule
